// File: rtl/cp0_reg_pkg.sv
// cp0_reg_pkg: CP0 register numbers, exception codes and the exception vector.
package cp0_reg_pkg;
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam logic [4:0] EXC_ERET = 5'h11;
  localparam logic [31:0] EXC_ADDR = 32'h0000_0100;
endpackage

// File: rtl/cp0_reg.sv
// cp0_reg: CP0 Count/Compare/Status/Cause/EPC with exception and interrupt arbitration.
module cp0_reg
  import cp0_reg_pkg::*;
(
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        re_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic        valid_i,
  input  logic [4:0]  exccode_i,
  input  logic [31:0] pc_i,
  input  logic        in_delay_i,
  input  logic [5:0]  int_i,
  output logic        flush_o,
  output logic [31:0] excaddr_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic        timer_int_o
);
  logic [31:0] count, compare, epc, rval;
  logic [7:0]  im, ip;
  logic [4:0]  exc, code;
  logic        exl, ie, bd, pre, pending, take;
  assign status_o = {16'b0, im, 6'b0, exl, ie};
  assign cause_o  = {bd, 15'b0, ip, 1'b0, exc, 2'b0};
  always_comb begin
    pending   = |(ip & im) && ie && !exl && valid_i;
    code      = pending ? EXC_INT : valid_i ? exccode_i : EXC_NONE;
    take      = code != EXC_NONE && code != EXC_ERET;
    flush_o   = !cpu_rst && code != EXC_NONE;
    excaddr_o = cpu_rst ? '0 : code == EXC_ERET ? epc : take ? EXC_ADDR : '0;
    rval      = raddr_i == CP0_COUNT   ? count :
                raddr_i == CP0_COMPARE ? compare :
                raddr_i == CP0_STATUS  ? status_o :
                raddr_i == CP0_CAUSE   ? cause_o :
                raddr_i == CP0_EPC     ? epc : '0;
    rdata_o   = (cpu_rst || !re_i) ? '0 : (we_i && waddr_i == raddr_i) ? wdata_i : rval;
  end
  // mtc0 updates come first so exception field updates below override them
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      count       <= '0;
      compare     <= '0;
      epc         <= '0;
      im          <= '0;
      ip          <= '0;
      exc         <= '0;
      exl         <= 1'b1;
      ie          <= 1'b0;
      bd          <= 1'b0;
      pre         <= 1'b0;
      timer_int_o <= 1'b0;
    end else begin
      pre <= ~pre;
      if (pre) count <= count + 32'd1;
      if (count == compare && compare != '0) timer_int_o <= 1'b1;
      ip[7:2] <= {int_i[5] | timer_int_o, int_i[4:0]};
      if (we_i) begin
        case (waddr_i)
          CP0_COUNT: begin
            count <= wdata_i;
            pre   <= 1'b0;
          end
          CP0_COMPARE: begin
            compare     <= wdata_i;
            timer_int_o <= 1'b0;
          end
          CP0_STATUS: begin
            im  <= wdata_i[15:8];
            exl <= wdata_i[1];
            ie  <= wdata_i[0];
          end
          CP0_CAUSE: ip[1:0] <= wdata_i[9:8];
          CP0_EPC:   epc <= wdata_i;
          default: ;
        endcase
      end
      if (take) begin
        if (!exl) begin
          epc <= in_delay_i ? pc_i - 32'd4 : pc_i;
          bd  <= in_delay_i;
        end
        exc <= code;
        exl <= 1'b1;
      end else if (code == EXC_ERET) begin
        exl <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg: register-level CP0 model with per-cycle compare plus directed scenarios.
module tb_cp0_reg;
  logic        clk = 0, rst = 1;
  logic        we = 0, re = 0, valid = 0, in_delay = 0;
  logic [4:0]  waddr = 0, raddr = 0, exccode = 5'h10;
  logic [31:0] wdata = 0, pc = 0;
  logic [5:0]  int_i = 0;
  logic [31:0] rdata, excaddr, status, cause;
  logic        flush, timer;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  cp0_reg dut (
    .cpu_clk_50M(clk), .cpu_rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata), .valid_i(valid), .exccode_i(exccode),
    .pc_i(pc), .in_delay_i(in_delay), .int_i(int_i), .flush_o(flush), .excaddr_o(excaddr),
    .status_o(status), .cause_o(cause), .timer_int_o(timer)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Count is "value loaded plus half the edges since", not a prescaled register
  logic [31:0] m_base = 0, m_n = 0, m_compare = 0, m_status = 32'h2, m_cause = 0, m_epc = 0;
  logic        m_timer = 0;

  function automatic logic [31:0] m_count();
    return m_base + (m_n >> 1);
  endfunction

  function automatic logic [31:0] m_reg(input logic [4:0] a);
    case (a)
      5'd9:  return m_count();
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause;
      5'd14: return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [4:0] m_code();
    logic pend;
    pend = ((m_cause[15:8] & m_status[15:8]) != 0) && m_status[0] && !m_status[1] && valid;
    return pend ? 5'h00 : valid ? exccode : 5'h10;
  endfunction

  logic [4:0]  c;
  logic [31:0] cnt_old;
  logic        exl_old, tim_old;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_base = 0; m_n = 0; m_compare = 0; m_status = 32'h2; m_cause = 0; m_epc = 0; m_timer = 0;
    end else begin
      c = m_code();
      cnt_old = m_count();
      exl_old = m_status[1];
      tim_old = m_timer;
      m_n = m_n + 1;
      if (cnt_old == m_compare && m_compare != 0) m_timer = 1;
      m_cause[15:10] = {int_i[5] | tim_old, int_i[4:0]};
      if (we) begin
        case (waddr)
          5'd9:  begin m_base = wdata; m_n = 0; end
          5'd11: begin m_compare = wdata; m_timer = 0; end
          5'd12: m_status = wdata & 32'h0000_FF03;
          5'd13: m_cause[9:8] = wdata[9:8];
          5'd14: m_epc = wdata;
          default: ;
        endcase
      end
      if (c != 5'h10 && c != 5'h11) begin
        if (!exl_old) begin
          m_epc = in_delay ? pc - 4 : pc;
          m_cause[31] = in_delay;
        end
        m_cause[6:2] = c;
        m_status[1] = 1'b1;
      end else if (c == 5'h11) begin
        m_status[1] = 1'b0;
      end
    end
  end

  logic [4:0] cc;
  always @(negedge clk) begin
    cc = m_code();
    chk("flush", {31'b0, flush}, {31'b0, !rst && cc != 5'h10});
    chk("excaddr", excaddr, rst ? 32'h0 : cc == 5'h11 ? m_epc : cc == 5'h10 ? 32'h0 : 32'h100);
    chk("rdata", rdata, (rst || !re) ? 32'h0 : (we && waddr == raddr) ? wdata : m_reg(raddr));
    chk("status", status, m_status);
    chk("cause", cause, m_cause);
    chk("timer", {31'b0, timer}, {31'b0, m_timer});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1; waddr = a; wdata = d;
    tick();
    we = 0;
  endtask

  int hit;
  initial begin
    repeat (2) @(posedge clk);
    #1 re = 1; raddr = 12;
    #1 chk("rst_rdata", rdata, 0);
    chk("rst_status", status, 32'h2);
    chk("rst_flush", {31'b0, flush}, 0);
    rst = 0;
    repeat (10) tick();
    raddr = 9;
    #1 chk("count_after_10", rdata, 5);
    chk("status_idle", status, 32'h2);
    // interrupt through IM2
    wr(12, 32'h401);
    int_i = 6'h01; valid = 1; pc = 32'h80;
    tick();
    chk("int_flush", {31'b0, flush}, 1);
    chk("int_excaddr", excaddr, 32'h100);
    tick();
    valid = 0; int_i = 0; raddr = 14;
    #1 chk("int_epc", rdata, 32'h80);
    chk("int_exccode", {27'b0, cause[6:2]}, 0);
    chk("int_status", status, 32'h403);
    // syscall in a delay slot
    wr(12, 32'h0);
    valid = 1; exccode = 5'h08; pc = 32'h44; in_delay = 1;
    #1 chk("sys_flush", {31'b0, flush}, 1);
    chk("sys_excaddr", excaddr, 32'h100);
    tick();
    valid = 0; in_delay = 0; exccode = 5'h10;
    #1 chk("sys_epc", rdata, 32'h40);
    chk("sys_bd", {31'b0, cause[31]}, 1);
    chk("sys_exccode", {27'b0, cause[6:2]}, 32'h08);
    // eret
    valid = 1; exccode = 5'h11;
    #1 chk("eret_flush", {31'b0, flush}, 1);
    chk("eret_excaddr", excaddr, 32'h40);
    tick();
    valid = 0; exccode = 5'h10;
    #1 chk("eret_exl", {31'b0, status[1]}, 0);
    // nested exception while EXL=1 keeps EPC
    valid = 1; exccode = 5'h08; pc = 32'h60;
    tick();
    exccode = 5'h0c; pc = 32'h90;
    #1 chk("nest_flush", {31'b0, flush}, 1);
    tick();
    valid = 0; exccode = 5'h10;
    #1 chk("nest_epc", rdata, 32'h60);
    chk("nest_exccode", {27'b0, cause[6:2]}, 32'h0c);
    // timer
    wr(11, 32'd20);
    raddr = 9;
    wr(9, 32'd0);
    hit = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (timer) begin
        hit = i;
        chk("timer_count", rdata, 20);
        break;
      end
    end
    chk("timer_rise_cycle", hit, 41);
    repeat (5) tick();
    chk("timer_hold", {31'b0, timer}, 1);
    wr(11, 32'd0);
    #1 chk("timer_clear", {31'b0, timer}, 0);
    // wrap
    wr(9, 32'hFFFF_FFFF);
    #1 chk("wrap_pre", rdata, 32'hFFFF_FFFF);
    tick(); tick();
    chk("wrap_post", rdata, 0);
    // write bypass with simultaneous exception
    raddr = 12; we = 1; waddr = 12; wdata = 32'h0000_FF01;
    valid = 1; exccode = 5'h08; pc = 32'h100;
    #1 chk("bypass", rdata, 32'h0000_FF01);
    tick();
    we = 0; valid = 0; exccode = 5'h10;
    #1 chk("wr_exc_status", status, 32'h0000_FF03);
    wr(13, 32'h300);
    #1 chk("cause_sw_ip", {30'b0, cause[9:8]}, 3);
    wr(5, 32'hDEAD_BEEF);
    raddr = 5;
    #1 chk("unimpl_read", rdata, 0);
    re = 0; raddr = 12;
    #1 chk("re_low", rdata, 0);
    // reset mid-exception
    re = 1; raddr = 14;
    wr(12, 32'h0);
    valid = 1; exccode = 5'h08; pc = 32'h200;
    #1 chk("pre_rst_flush", {31'b0, flush}, 1);
    #1 rst = 1;
    #1 chk("mid_rst_flush", {31'b0, flush}, 0);
    chk("mid_rst_status", status, 32'h2);
    chk("mid_rst_rdata", rdata, 0);
    tick();
    rst = 0; valid = 0; exccode = 5'h10;
    tick();
    chk("post_rst_epc", rdata, 0);
    chk("post_rst_cause", cause, 0);
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
